// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first. Two-flop synchronizer, start bit validated at
// its midpoint, data and stop bits sampled one bit period apart.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;

  // NOTE: every register here, including the shift register and byte holder, has
  // a defined reset value so the outputs are deterministic straight out of reset.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops
      // update together from the values present before the edge.
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sync1_q   <= i_RX_Serial;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q < HALF) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          // A line already back high at mid-start-bit was a glitch.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q < BIT_LAST) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (clk_cnt_q < BIT_LAST) begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end else begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        // Hold here through a break until the line releases.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    active_d = (state_d != S_IDLE);
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Active    = active_q;
  assign o_RX_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8 (H=3): reset, single byte, back-to-back,
// glitch, framing error with break, and reset mid-frame.
module tb_uart_rx;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic       act;
  logic       ferr;
  logic [7:0] byte_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_RX_Serial   (rx),
    .o_RX_DV       (dv),
    .o_RX_Byte     (byte_o),
    .o_RX_Active   (act),
    .o_RX_Frame_Err(ferr)
  );

  // Cycle counter: value k after the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  int         dv_cyc[$];
  logic [7:0] dv_byte[$];
  int         ferr_cyc[$];
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  int         viol = 0;
  logic       prev_act = 1'b0;
  logic       prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (dv) begin
      dv_cyc.push_back(cyc);
      dv_byte.push_back(byte_o);
    end
    if (ferr) ferr_cyc.push_back(cyc);
    if ((dv && ferr) || ((dv || ferr) && prev_pulse)) viol <= viol + 1;
    prev_pulse <= dv || ferr;
    if (act && !prev_act) rise_cyc <= cyc;
    if (!act && prev_act) fall_cyc <= cyc;
    prev_act <= act;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_byte.delete();
    ferr_cyc.delete();
  endtask

  // Drives the first nbits of {stop, data, start}, C clocks per bit; call just after a rising edge.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      idle(C);
    end
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    idle(4);
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b exp 0", dv); end
    checks++; if (byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h exp 00", byte_o); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", act); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", ferr); end
    rst_n = 1'b1;
    idle(6);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL post_reset_active: got %b exp 0", act); end
    checks++; if (dv_cyc.size() != 0) begin errors++; $display("FAIL post_reset_dv: got %0d pulses exp 0", dv_cyc.size()); end
  endtask

  task automatic test_single_byte();
    int start;
    sync_edge();
    clear_log();
    start = cyc;
    send_bits(8'h5A, 1'b1, 10);
    idle(3);
    checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL single_dv_count: got %0d exp 1", dv_cyc.size()); end
    checks++; if (dv_cyc[0] != start + 79) begin errors++; $display("FAIL single_dv_cycle: got %0d exp %0d", dv_cyc[0], start + 79); end
    checks++; if (dv_byte[0] !== 8'h5A) begin errors++; $display("FAIL single_byte: got %h exp 5a", dv_byte[0]); end
    checks++; if (byte_o !== 8'h5A) begin errors++; $display("FAIL single_byte_hold: got %h exp 5a", byte_o); end
    checks++; if (rise_cyc != start + 3) begin errors++; $display("FAIL single_active_rise: got %0d exp %0d", rise_cyc, start + 3); end
    checks++; if (fall_cyc != start + 80) begin errors++; $display("FAIL single_active_fall: got %0d exp %0d", fall_cyc, start + 80); end
    checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL single_ferr: got %0d exp 0", ferr_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int start;
    sync_edge();
    clear_log();
    start = cyc;
    send_bits(8'h00, 1'b1, 10);
    send_bits(8'hFF, 1'b1, 10);
    idle(3);
    checks++; if (dv_cyc.size() != 2) begin errors++; $display("FAIL b2b_dv_count: got %0d exp 2", dv_cyc.size()); end
    checks++; if (dv_cyc[0] != start + 79) begin errors++; $display("FAIL b2b_first_cycle: got %0d exp %0d", dv_cyc[0], start + 79); end
    checks++; if (dv_cyc[1] - dv_cyc[0] != 10 * C) begin errors++; $display("FAIL b2b_spacing: got %0d exp %0d", dv_cyc[1] - dv_cyc[0], 10 * C); end
    checks++; if (dv_byte[0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h exp 00", dv_byte[0]); end
    checks++; if (dv_byte[1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h exp ff", dv_byte[1]); end
    checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL b2b_ferr: got %0d exp 0", ferr_cyc.size()); end
  endtask

  task automatic test_glitch();
    int start;
    sync_edge();
    clear_log();
    start = cyc;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(15);
    checks++; if (dv_cyc.size() != 0) begin errors++; $display("FAIL glitch_dv: got %0d exp 0", dv_cyc.size()); end
    checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL glitch_ferr: got %0d exp 0", ferr_cyc.size()); end
    checks++; if (byte_o !== 8'hFF) begin errors++; $display("FAIL glitch_byte_hold: got %h exp ff", byte_o); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b exp 0", act); end
    checks++; if (rise_cyc != start + 3) begin errors++; $display("FAIL glitch_active_rise: got %0d exp %0d", rise_cyc, start + 3); end
    checks++; if (fall_cyc - rise_cyc != 4) begin errors++; $display("FAIL glitch_active_len: got %0d exp 4", fall_cyc - rise_cyc); end
    clear_log();
    start = cyc;
    send_bits(8'h3C, 1'b1, 10);
    idle(3);
    checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL glitch_next_count: got %0d exp 1", dv_cyc.size()); end
    checks++; if (dv_byte[0] !== 8'h3C) begin errors++; $display("FAIL glitch_next_byte: got %h exp 3c", dv_byte[0]); end
    checks++; if (dv_cyc[0] != start + 79) begin errors++; $display("FAIL glitch_next_cycle: got %0d exp %0d", dv_cyc[0], start + 79); end
  endtask

  task automatic test_frame_error();
    int start;
    sync_edge();
    clear_log();
    send_bits(8'h11, 1'b1, 10);
    start = cyc;
    send_bits(8'hA5, 1'b0, 10);
    idle(30);
    checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL ferr_dv_count: got %0d exp 1", dv_cyc.size()); end
    checks++; if (dv_byte[0] !== 8'h11) begin errors++; $display("FAIL ferr_good_byte: got %h exp 11", dv_byte[0]); end
    checks++; if (ferr_cyc.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d exp 1", ferr_cyc.size()); end
    checks++; if (ferr_cyc[0] != start + 79) begin errors++; $display("FAIL ferr_cycle: got %0d exp %0d", ferr_cyc[0], start + 79); end
    checks++; if (byte_o !== 8'h11) begin errors++; $display("FAIL ferr_byte_hold: got %h exp 11", byte_o); end
    checks++; if (act !== 1'b1) begin errors++; $display("FAIL ferr_active_break: got %b exp 1", act); end
    rx = 1'b1;
    idle(5);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL ferr_release: got %b exp 0", act); end
    clear_log();
    send_bits(8'h7E, 1'b1, 10);
    idle(3);
    checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL ferr_next_count: got %0d exp 1", dv_cyc.size()); end
    checks++; if (dv_byte[0] !== 8'h7E) begin errors++; $display("FAIL ferr_next_byte: got %h exp 7e", dv_byte[0]); end
    checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL ferr_next_ferr: got %0d exp 0", ferr_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    sync_edge();
    clear_log();
    send_bits(8'hC3, 1'b1, 5);
    rx = 1'b0;
    idle(4);
    rst_n = 1'b0;
    rx = 1'b1;
    idle(3);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL midrst_active: got %b exp 0", act); end
    checks++; if (byte_o !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h exp 00", byte_o); end
    rst_n = 1'b1;
    idle(12 * C);
    checks++; if (dv_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_dv: got %0d exp 0", dv_cyc.size()); end
    checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_ferr: got %0d exp 0", ferr_cyc.size()); end
    send_bits(8'h96, 1'b1, 10);
    idle(3);
    checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL midrst_next_count: got %0d exp 1", dv_cyc.size()); end
    checks++; if (dv_byte[0] !== 8'h96) begin errors++; $display("FAIL midrst_next_byte: got %h exp 96", dv_byte[0]); end
  endtask

  task automatic test_pulse_rules();
    idle(2);
    checks++; if (viol != 0) begin errors++; $display("FAIL pulse_rules: got %0d violations exp 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity. Oversamples the asynchronous `i_RX_Serial` line with the system clock, validates the start bit at its midpoint and samples each data bit at its midpoint. Presents each good byte with a one-cycle valid strobe. Sits between the board RX pin and the host-side byte consumer, opposite the existing UART transmitter, and shares its `CLKS_PER_BIT` convention.

## Interface
- `CLKS_PER_BIT`, default 217: system clocks per bit period, equal to f(i_Clock)/baud. Legal range 4..65535.
- `i_Clock` in 1: system clock. One clock domain, rising-edge only.
- `i_Rst_n` in 1: reset, asynchronous and active-low.
- `i_RX_Serial` in 1: raw serial line, asynchronous to `i_Clock`; idles high.
- `o_RX_DV` out 1: one-cycle pulse when a byte with a valid stop bit has been received.
- `o_RX_Byte` out 8: last good byte. Updated only when `o_RX_DV` rises; holds otherwise.
- `o_RX_Active` out 1: high whenever the state machine is not in IDLE.
- `o_RX_Frame_Err` out 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Input synchronizer: two flops on `i_RX_Serial`, both reset to 1. All decisions use the second flop, `rx_s`.
- Bit counter: 16-bit `clk_cnt`. Bit index: 3 bits. Shift register: 8 bits. Define H = (CLKS_PER_BIT-1)/2, using integer division.
- IDLE:
  - `clk_cnt`=0 and bit index=0.
  - `rx_s`=0 → go to START.
- START:
  - While `clk_cnt`<H, increment `clk_cnt`.
  - At `clk_cnt`==H: if `rx_s`=0, clear `clk_cnt` and go to DATA. If `rx_s`=1, treat it as a glitch and return to IDLE with no outputs pulsed.
- DATA:
  - While `clk_cnt`<CLKS_PER_BIT-1, increment `clk_cnt`.
  - At `clk_cnt`==CLKS_PER_BIT-1: clear `clk_cnt` and write `rx_s` into shift[bit index].
  - Bit index<7 → increment the index and stay in DATA. Otherwise clear the index and go to STOP.
- STOP:
  - Count as in DATA.
  - At `clk_cnt`==CLKS_PER_BIT-1 with `rx_s`=1: `o_RX_Byte`<=shift and `o_RX_DV`<=1.
  - At `clk_cnt`==CLKS_PER_BIT-1 with `rx_s`=0: `o_RX_Frame_Err`<=1 and `o_RX_Byte` is unchanged.
  - Either case → CLEANUP.
- CLEANUP:
  - `o_RX_DV` and `o_RX_Frame_Err` return to 0.
  - Leave for IDLE only when `rx_s`=1. This covers the wait for the line to release after a break or framing error.
  - If `rx_s` is already 1, stay exactly one cycle.
- Undefined state encodings → IDLE.
- `o_RX_Active` is registered: 1 from the edge entering START until the edge entering IDLE.

## Timing
- Reset values, applied asynchronously while `i_Rst_n`=0:
  - State=IDLE, all counters=0, shift=0, synchronizer flops=1.
  - `o_RX_DV`=0, `o_RX_Byte`=8'h00, `o_RX_Active`=0, `o_RX_Frame_Err`=0.
- Reset mid-frame aborts the frame: no DV and no error pulse. After release, the receiver waits for a fresh falling edge.
- Latency: let e0 be the first clock edge that samples `i_RX_Serial` low.
  - `rx_s` goes low at e1 and the state enters START at e2.
  - `o_RX_DV` (or `o_RX_Frame_Err`) is high for exactly the one cycle after edge e2+9·CLKS_PER_BIT+H+1.
- Sampling points: the start bit at its midpoint, each data bit and the stop bit one full period later. All sampling is relative to the detected falling edge plus 2 synchronizer cycles.
- Glitch rejection: a low pulse shorter than about H+1 clocks never produces DV or error. `o_RX_Active` pulses for H+1 cycles.
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is accepted. Supports a 1-stop-bit stream at full baud with up to ±(H/CLKS_PER_BIT)/9.5 of clock mismatch.
- `o_RX_DV` and `o_RX_Frame_Err` are mutually exclusive and never high for 2 consecutive cycles.

## Test plan
- **Reset values:** hold `i_Rst_n`=0 with `i_RX_Serial`=1 → all outputs 0, `o_RX_Byte`=8'h00. Release reset → outputs stay idle.
- **Single byte:** CLKS_PER_BIT=8 (H=3), send 8'h5A → `o_RX_DV` high exactly 1 cycle after edge e0+78, `o_RX_Byte`=8'h5A. `o_RX_Active` falls one cycle after the DV pulse.
- **Back-to-back bytes:** send 8'h00 then 8'hFF with no idle gap → two DV pulses 10·CLKS_PER_BIT clocks apart, bytes 8'h00 then 8'hFF, no `o_RX_Frame_Err`.
- **Glitch:** drive `i_RX_Serial` low for 2 cycles, then high → no DV, no error, `o_RX_Byte` unchanged. The state returns to IDLE and the next valid 8'h3C is received correctly.
- **Framing error:** after a good 8'h11, send 8'hA5 with stop bit=0, then hold the line low 30 cycles (break) → one `o_RX_Frame_Err` pulse and `o_RX_Byte` stays 8'h11. `o_RX_Active` stays 1 until the line returns high; the next byte 8'h7E is received correctly.
- **Reset mid-frame:** assert `i_Rst_n`=0 during data bit 4 of 8'hC3, release it, then send 8'h96 → no DV for the aborted frame, then a DV pulse with 8'h96.
